// File: rtl/lc3b_types.sv
// Shared type definitions for the victim cache controller.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    WB_WAIT = 2'd2,
    WB      = 2'd3
  } vc_state_t;

endpackage

// File: rtl/victim_lru.sv
// True-LRU tracker: one age counter per way, age 0 = most recently used.
module victim_lru #(
  parameter  int unsigned NUM_WAYS = 8,
  localparam int unsigned IDX_W    = $clog2(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch,
  input  logic [IDX_W-1:0] way,
  output logic [IDX_W-1:0] lru_way
);

  logic [IDX_W-1:0] age_q [NUM_WAYS];
  logic [IDX_W-1:0] age_d [NUM_WAYS];
  logic [IDX_W-1:0] lru_q;
  logic [IDX_W-1:0] lru_d;

  // Touched way becomes youngest; only ways younger than it age, so ages stay a permutation.
  always_comb begin
    for (int i = 0; i < NUM_WAYS; i++) begin
      age_d[i] = age_q[i];
    end
    if (touch) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        if (IDX_W'(i) == way) begin
          age_d[i] = '0;
        end else if (age_q[i] < age_q[way]) begin
          age_d[i] = age_q[i] + IDX_W'(1);
        end
      end
    end
  end

  // The oldest way (age NUM_WAYS-1) is the replacement candidate.
  always_comb begin
    lru_d = lru_q;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (age_d[i] == IDX_W'(NUM_WAYS - 1)) begin
        lru_d = IDX_W'(i);
      end
    end
  end

  // Age and LRU-index registers; reset gives way i age i.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        age_q[i] <= IDX_W'(i);
      end
      lru_q <= IDX_W'(NUM_WAYS - 1);
    end else begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        age_q[i] <= age_d[i];
      end
      lru_q <= lru_d;
    end
  end

  assign lru_way = lru_q;

endmodule

// File: rtl/param_victim_cache.sv
// Fully associative victim cache between L2 and physical memory, with dirty writeback.
module param_victim_cache
  import lc3b_types::*;
#(
  parameter int unsigned NUM_WAYS  = 8,
  parameter int unsigned LINE_BITS = 128,
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 L2_read,
  input  logic                 L2_write,
  input  logic [ADDR_BITS-1:0] L2_address,
  input  logic [LINE_BITS-1:0] L2_data,
  input  logic                 L2_dirty_bit,
  input  logic                 L2toPmem_busy,
  input  logic                 mem_ack,
  output logic                 VC_ack,
  output logic                 VC_hit,
  output logic [LINE_BITS-1:0] VC_rdata,
  output logic                 VC_rdirty,
  output logic                 wb_write,
  output logic [ADDR_BITS-1:0] wb_address,
  output logic [LINE_BITS-1:0] wb_data
);

  localparam int unsigned IDX_W = $clog2(NUM_WAYS);

  vc_state_t            state_q, state_d;
  logic [NUM_WAYS-1:0]  valid_q, valid_d;
  logic [NUM_WAYS-1:0]  dirty_q, dirty_d;
  logic [ADDR_BITS-1:0] tag_q  [NUM_WAYS];
  logic [LINE_BITS-1:0] data_q [NUM_WAYS];
  logic [IDX_W-1:0]     victim_q, victim_d;

  logic                 ack_q, ack_d;
  logic                 hit_q, hit_d;
  logic                 rdirty_q, rdirty_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;
  logic                 wb_write_q, wb_write_d;
  logic [ADDR_BITS-1:0] wb_addr_q, wb_addr_d;
  logic [LINE_BITS-1:0] wb_data_q, wb_data_d;

  logic                 wr_en;
  logic [IDX_W-1:0]     wr_way;
  logic                 touch;
  logic [IDX_W-1:0]     lru_way;
  logic [IDX_W-1:0]     tgt;
  logic                 match_any, inv_any;
  logic [IDX_W-1:0]     match_way, inv_way;

  victim_lru #(
    .NUM_WAYS (NUM_WAYS)
  ) u_lru (
    .clk     (clk),
    .rst     (rst),
    .touch   (touch),
    .way     (wr_way),
    .lru_way (lru_way)
  );

  // Tag match and lowest-index invalid way search.
  always_comb begin
    match_any = 1'b0;
    match_way = '0;
    inv_any   = 1'b0;
    inv_way   = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == L2_address)) begin
        match_any = 1'b1;
        match_way = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        inv_any = 1'b1;
        inv_way = IDX_W'(i);
      end
    end
  end

  // Controller next-state, array write port and registered-output next values.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    victim_d   = victim_q;
    ack_d      = 1'b0;
    hit_d      = 1'b0;
    rdirty_d   = 1'b0;
    rdata_d    = '0;
    wb_write_d = wb_write_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wr_en      = 1'b0;
    wr_way     = victim_q;
    touch      = 1'b0;
    tgt        = lru_way;

    case (state_q)
      IDLE: begin
        if (L2_read) begin
          // Hit swaps the line back to L2, so the way is freed without an LRU update.
          ack_d   = 1'b1;
          state_d = ACK;
          if (match_any) begin
            hit_d              = 1'b1;
            rdata_d            = data_q[match_way];
            rdirty_d           = dirty_q[match_way];
            valid_d[match_way] = 1'b0;
            dirty_d[match_way] = 1'b0;
          end
        end else if (L2_write) begin
          if (match_any) begin
            tgt = match_way;
          end else if (inv_any) begin
            tgt = inv_way;
          end
          if (!match_any && !inv_any && dirty_q[lru_way]) begin
            victim_d = lru_way;
            state_d  = WB_WAIT;
          end else begin
            wr_en        = 1'b1;
            wr_way       = tgt;
            valid_d[tgt] = 1'b1;
            dirty_d[tgt] = L2_dirty_bit | (match_any & dirty_q[tgt]);
            touch        = 1'b1;
            ack_d        = 1'b1;
            state_d      = ACK;
          end
        end
      end
      WB_WAIT: begin
        if (!L2toPmem_busy) begin
          wb_write_d = 1'b1;
          wb_addr_d  = tag_q[victim_q];
          wb_data_d  = data_q[victim_q];
          state_d    = WB;
        end
      end
      WB: begin
        if (mem_ack) begin
          wb_write_d        = 1'b0;
          wb_addr_d         = '0;
          wb_data_d         = '0;
          wr_en             = 1'b1;
          wr_way            = victim_q;
          valid_d[victim_q] = 1'b1;
          dirty_d[victim_q] = L2_dirty_bit;
          touch             = 1'b1;
          ack_d             = 1'b1;
          state_d           = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      victim_q   <= '0;
      ack_q      <= 1'b0;
      hit_q      <= 1'b0;
      rdirty_q   <= 1'b0;
      rdata_q    <= '0;
      wb_write_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      victim_q   <= victim_d;
      ack_q      <= ack_d;
      hit_q      <= hit_d;
      rdirty_q   <= rdirty_d;
      rdata_q    <= rdata_d;
      wb_write_q <= wb_write_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Tag/data storage; contents are qualified by valid_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_way]  <= L2_address;
      data_q[wr_way] <= L2_data;
    end
  end

  assign VC_ack     = ack_q;
  assign VC_hit     = hit_q;
  assign VC_rdata   = rdata_q;
  assign VC_rdirty  = rdirty_q;
  assign wb_write   = wb_write_q;
  assign wb_address = wb_addr_q;
  assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_param_victim_cache.sv
// Bench for param_victim_cache (4 ways): directed scenarios plus random traffic vs. a reference model.
module tb_param_victim_cache;

  localparam int unsigned NW = 4;
  localparam int unsigned LB = 128;
  localparam int unsigned AB = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          L2_read, L2_write, L2_dirty_bit, L2toPmem_busy, mem_ack;
  logic [AB-1:0] L2_address;
  logic [LB-1:0] L2_data;
  logic          VC_ack, VC_hit, VC_rdirty, wb_write;
  logic [LB-1:0] VC_rdata, wb_data;
  logic [AB-1:0] wb_address;

  int checks   = 0;
  int failures = 0;

  // Reference model: line contents per way plus a recency list (front = most recent).
  bit            m_valid [NW];
  bit            m_dirty [NW];
  logic [AB-1:0] m_tag   [NW];
  logic [LB-1:0] m_data  [NW];
  int            m_order [$];

  always #5 clk = ~clk;

  param_victim_cache #(
    .NUM_WAYS  (NW),
    .LINE_BITS (LB),
    .ADDR_BITS (AB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .L2_read       (L2_read),
    .L2_write      (L2_write),
    .L2_address    (L2_address),
    .L2_data       (L2_data),
    .L2_dirty_bit  (L2_dirty_bit),
    .L2toPmem_busy (L2toPmem_busy),
    .mem_ack       (mem_ack),
    .VC_ack        (VC_ack),
    .VC_hit        (VC_hit),
    .VC_rdata      (VC_rdata),
    .VC_rdirty     (VC_rdirty),
    .wb_write      (wb_write),
    .wb_address    (wb_address),
    .wb_data       (wb_data)
  );

  task automatic chk(input string name, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [LB-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    m_order.delete();
    for (int i = 0; i < NW; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_order.push_back(i);
    end
  endtask

  task automatic model_touch(input int w);
    for (int i = 0; i < m_order.size(); i++) begin
      if (m_order[i] == w) begin
        m_order.delete(i);
        break;
      end
    end
    m_order.push_front(w);
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1; L2_read = 1'b0; L2_write = 1'b0; L2_dirty_bit = 1'b0;
    L2toPmem_busy = 1'b0; mem_ack = 1'b0; L2_address = '0; L2_data = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({name, ".ack"},    LB'(VC_ack), '0);
    chk({name, ".hit"},    LB'(VC_hit), '0);
    chk({name, ".rdirty"}, LB'(VC_rdirty), '0);
    chk({name, ".rdata"},  VC_rdata, '0);
    chk({name, ".wbw"},    LB'(wb_write), '0);
    chk({name, ".wbaddr"}, LB'(wb_address), '0);
    chk({name, ".wbdata"}, wb_data, '0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_read(input logic [AB-1:0] a, input string name);
    int hw;
    int n;
    bit got;
    logic [LB-1:0] exp_data;
    hw = -1;
    for (int i = 0; i < NW; i++) begin
      if (m_valid[i] && m_tag[i] == a) begin
        hw = i;
        break;
      end
    end
    exp_data = (hw >= 0) ? m_data[hw] : '0;
    L2_address = a; L2_read = 1'b1;
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(posedge clk); #1; n++;
      if (VC_ack) got = 1'b1;
    end
    L2_read = 1'b0;
    chk({name, ".ack"},    LB'(got), LB'(1));
    chk({name, ".lat"},    LB'(n), LB'(1));
    chk({name, ".hit"},    LB'(VC_hit), LB'(hw >= 0));
    chk({name, ".rdata"},  VC_rdata, exp_data);
    chk({name, ".rdirty"}, LB'(VC_rdirty), LB'((hw >= 0) && m_dirty[hw]));
    if (hw >= 0) begin
      m_valid[hw] = 1'b0;
      m_dirty[hw] = 1'b0;
    end
    @(posedge clk); #1;
    chk({name, ".dead"}, LB'(VC_ack), '0);
  endtask

  task automatic do_write(input logic [AB-1:0] a, input logic [LB-1:0] d, input bit dt,
                          input int busy, input int mdelay, input string name);
    int hw, tgt, n, wb_edge, mwait, exp_lat;
    bit need_wb, got, any_inv;
    logic [AB-1:0] vtag;
    logic [LB-1:0] vdata;
    hw = -1; tgt = -1; any_inv = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (hw < 0 && m_valid[i] && m_tag[i] == a) hw = i;
    end
    for (int i = NW - 1; i >= 0; i--) begin
      if (!m_valid[i]) begin
        any_inv = 1'b1;
        tgt = i;
      end
    end
    if (hw >= 0) tgt = hw;
    else if (!any_inv) tgt = m_order[$];
    need_wb = (hw < 0) && !any_inv && m_dirty[tgt];
    vtag  = m_tag[tgt];
    vdata = m_data[tgt];
    exp_lat = need_wb ? busy + mdelay + 3 : 1;

    L2_address = a; L2_data = d; L2_dirty_bit = dt; L2_write = 1'b1; mem_ack = 1'b0;
    n = 0; got = 1'b0; wb_edge = 0; mwait = 0;
    while (n < 60 && !got) begin
      L2toPmem_busy = (busy > 0) && (n <= busy);
      @(posedge clk); #1; n++;
      if (VC_ack) begin
        got = 1'b1;
      end else if (wb_write) begin
        if (wb_edge == 0) wb_edge = n;
        chk({name, ".wbaddr"}, LB'(wb_address), LB'(vtag));
        chk({name, ".wbdata"}, wb_data, vdata);
        mem_ack = (mwait >= mdelay);
        mwait++;
      end else begin
        mem_ack = 1'b0;
      end
    end
    mem_ack = 1'b0; L2_write = 1'b0; L2toPmem_busy = 1'b0;
    chk({name, ".ack"},    LB'(got), LB'(1));
    chk({name, ".lat"},    LB'(n), LB'(exp_lat));
    chk({name, ".wbedge"}, LB'(wb_edge), need_wb ? LB'(busy + 2) : '0);
    m_valid[tgt] = 1'b1;
    m_tag[tgt]   = a;
    m_data[tgt]  = d;
    m_dirty[tgt] = dt | ((hw >= 0) && m_dirty[tgt]);
    model_touch(tgt);
    @(posedge clk); #1;
    chk({name, ".dead"},   LB'(VC_ack), '0);
    chk({name, ".wbdrop"}, LB'(wb_write), '0);
  endtask

  task automatic do_both(input logic [AB-1:0] a, input logic [LB-1:0] d, input bit dt,
                         input string name);
    L2_address = a; L2_data = d; L2_dirty_bit = dt; L2_write = 1'b1;
    do_read(a, {name, ".rd"});
    do_write(a, d, dt, 0, 0, {name, ".wr"});
  endtask

  initial begin
    int n;
    int op;
    logic [AB-1:0] ra;

    do_reset("reset");

    do_read(12'h123, "miss0");

    do_write(12'h010, {16{8'hA5}}, 1'b0, 0, 0, "ins010");
    do_read(12'h010, "hit010");
    do_read(12'h010, "rehit010");

    do_write(12'h001, rand_line(), 1'b1, 0, 0, "ins001");
    do_write(12'h002, rand_line(), 1'b0, 0, 0, "ins002");
    do_write(12'h003, rand_line(), 1'b0, 0, 0, "ins003");
    do_write(12'h004, rand_line(), 1'b0, 0, 0, "ins004");
    do_write(12'h005, rand_line(), 1'b0, 3, 1, "evict001");
    do_read(12'h001, "gone001");

    do_both(12'h003, rand_line(), 1'b1, "both");

    do_reset("reset2");
    for (int i = 1; i <= 4; i++) do_write(AB'(i), rand_line(), 1'b0, 0, 0, "fill");
    do_write(12'h002, rand_line(), 1'b0, 0, 0, "reins002");
    do_write(12'h006, rand_line(), 1'b0, 0, 0, "ins006");
    do_read(12'h001, "lru001");
    do_read(12'h002, "keep002");
    do_write(12'h007, rand_line(), 1'b1, 0, 0, "dirtyor.a");
    do_write(12'h007, rand_line(), 1'b0, 0, 0, "dirtyor.b");
    do_read(12'h007, "dirtyor.rd");

    do_reset("reset3");
    for (int i = 1; i <= 4; i++) do_write(AB'(12'h020 + i), rand_line(), 1'b1, 0, 0, "dfill");
    L2_address = 12'h030; L2_data = rand_line(); L2_dirty_bit = 1'b0;
    L2_write = 1'b1; L2toPmem_busy = 1'b0; mem_ack = 1'b0;
    n = 0;
    while (n < 10 && !wb_write) begin
      @(posedge clk); #1; n++;
    end
    chk("midwb.rise", LB'(wb_write), LB'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midwb.drop", LB'(wb_write), '0);
    chk("midwb.noack", LB'(VC_ack), '0);
    L2_write = 1'b0; rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("midwb.noack2", LB'(VC_ack), '0);
    for (int i = 1; i <= 4; i++) do_read(AB'(12'h020 + i), "midwb.miss");
    do_read(12'h030, "midwb.miss030");

    for (int k = 0; k < 150; k++) begin
      op = int'($urandom_range(0, 9));
      ra = AB'(12'h100 + $urandom_range(0, 7));
      if (op < 4) begin
        do_read(ra, "rnd.rd");
      end else if (op < 9) begin
        do_write(ra, rand_line(), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "rnd.wr");
      end else begin
        do_both(ra, rand_line(), 1'($urandom_range(0, 1)), "rnd.both");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
